// File: rtl/tdm_pkg.sv
// Shared types and constants for the 10-channel TDM receive demux.
// Holds the FSM state encoding, default sizing and a slot-match helper.
package tdm_pkg;

   localparam int DEF_NCH = 10;
   localparam int DEF_SW  = 4;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   // One bit of the one-hot vector for slot index idx: high when idx == k.
   function automatic logic slot_hit(input int unsigned idx,
                                     input int unsigned k);
      return idx == k;
   endfunction

endpackage

// File: rtl/tdm_demux10_if.sv
// Serial-in / parallel-out bundle between the TDM link and its consumers.
// master: drives din/din_valid/sof; slave (the demux): drives frame/strobes.
interface tdm_demux10_if #(
   parameter int NCH = 10,
   parameter int SW  = 4
);
   logic           din;
   logic           din_valid;
   logic           sof;
   logic [NCH-1:0] frame;
   logic           frame_valid;
   logic [NCH-1:0] ch_strobe;
   logic           ch_bit;
   logic [SW-1:0]  slot;
   logic           sync_err;

   modport master (
      output din, din_valid, sof,
      input  frame, frame_valid, ch_strobe,
      input  ch_bit, slot, sync_err
   );

   modport slave (
      input  din, din_valid, sof,
      output frame, frame_valid, ch_strobe,
      output ch_bit, slot, sync_err
   );
endinterface

// File: rtl/tdm_slot_dec.sv
// Binary slot index to one-hot decoder with enable (combinational).
// i_en: enable, i_sel: slot index, o_onehot: NCH-wide one-hot (0 if !i_en).
module tdm_slot_dec
   import tdm_pkg::*;
#(
   parameter int NCH = DEF_NCH,
   parameter int SW  = DEF_SW
) (
   input  logic           i_en,
   input  logic [SW-1:0]  i_sel,
   output logic [NCH-1:0] o_onehot
);

   always_comb begin
      o_onehot = '0;
      for (int k = 0; k < NCH; k++) begin
         o_onehot[k] = i_en & slot_hit(32'(i_sel), unsigned'(k));
      end
   end

endmodule

// File: rtl/tdm_demux10.sv
// TDM receive demux: rebuilds the NCH-bit frame from a serial slot stream
// and strobes each accepted bit onto its own channel.
// Ports: clk, rst_n (sync, active-low), bus (slave modport of tdm_demux10_if).
module tdm_demux10
   import tdm_pkg::*;
#(
   parameter int NCH = DEF_NCH,
   parameter int SW  = DEF_SW
) (
   input  logic         clk,
   input  logic         rst_n,
   tdm_demux10_if.slave bus
);

   localparam logic [SW-1:0] LAST = SW'(NCH - 1);

   state_t         r_state;
   state_t         w_state_nxt;
   logic [SW-1:0]  r_slot;
   logic [SW-1:0]  w_slot_nxt;
   logic [SW-1:0]  w_idx;
   logic [NCH-1:0] r_buf;
   logic [NCH-1:0] w_buf_nxt;
   logic [NCH-1:0] r_frame;
   logic [NCH-1:0] w_frame_nxt;
   logic [NCH-1:0] w_we;
   logic [NCH-1:0] r_strobe;
   logic           r_fv;
   logic           w_fv_nxt;
   logic           r_err;
   logic           w_err_nxt;
   logic           r_bit;
   logic           w_acc;
   logic           w_coll;
   logic           w_last;

   // A bit is taken when it opens a frame (sof) or continues one.
   // Out-of-range slot values collapse onto the final slot.
   always_comb begin
      w_coll = (r_state == COLLECT);
      w_acc  = bus.din_valid & (bus.sof | w_coll);
      w_last = w_coll & ~bus.sof & (r_slot >= LAST);
      w_idx  = r_slot;
      if (bus.sof) begin
         w_idx = '0;
      end else if (r_slot >= LAST) begin
         w_idx = LAST;
      end
   end

   tdm_slot_dec #(
      .NCH (NCH),
      .SW  (SW)
   ) u_dec (
      .i_en     (w_acc),
      .i_sel    (w_idx),
      .o_onehot (w_we)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_slot_nxt  = r_slot;
      w_frame_nxt = r_frame;
      w_fv_nxt    = 1'b0;
      w_err_nxt   = 1'b0;
      w_buf_nxt   = (r_buf & ~w_we) | (w_we & {NCH{bus.din}});
      if (bus.din_valid) begin
         unique case (1'b1)
            bus.sof: begin
               w_state_nxt = COLLECT;
               w_slot_nxt  = SW'(1);
               w_err_nxt   = w_coll;
            end
            (~bus.sof & ~w_coll): begin
            end
            w_last: begin
               w_frame_nxt = w_buf_nxt;
               w_fv_nxt    = 1'b1;
               w_slot_nxt  = '0;
               w_state_nxt = IDLE;
            end
            (~bus.sof & w_coll & ~w_last): begin
               w_slot_nxt = r_slot + SW'(1);
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_slot   <= '0;
         r_buf    <= '0;
         r_frame  <= '0;
         r_fv     <= 1'b0;
         r_strobe <= '0;
         r_bit    <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_slot   <= w_slot_nxt;
         r_buf    <= w_buf_nxt;
         r_frame  <= w_frame_nxt;
         r_fv     <= w_fv_nxt;
         r_strobe <= w_we;
         r_err    <= w_err_nxt;
         if (w_acc) begin
            r_bit <= bus.din;
         end
      end
   end

   assign bus.frame       = r_frame;
   assign bus.frame_valid = r_fv;
   assign bus.ch_strobe   = r_strobe;
   assign bus.ch_bit      = r_bit;
   assign bus.slot        = r_slot;
   assign bus.sync_err    = r_err;

endmodule

// File: tb/tb_tdm_demux10.sv
// Self-checking bench for tdm_demux10: directed frames plus random traffic.
// Reference model keeps the partial frame as a queue of received bits.
module tb_tdm_demux10;

   localparam int NCH = 10;
   localparam int SW  = 4;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   tdm_demux10_if #(.NCH(NCH), .SW(SW)) bus ();

   tdm_demux10 #(
      .NCH (NCH),
      .SW  (SW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic           part[$];
   logic           m_coll;
   logic [NCH-1:0] m_frame;
   logic           m_fv;
   logic [NCH-1:0] m_stb;
   logic           m_bit;
   logic           m_err;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t",
                  tag, obs, exp, $time);
      end
   endtask

   task automatic model(input logic r, input logic v,
                        input logic s, input logic d);
      m_fv  = 1'b0;
      m_stb = '0;
      m_err = 1'b0;
      if (!r) begin
         part.delete();
         m_coll  = 1'b0;
         m_frame = '0;
         m_bit   = 1'b0;
      end else if (v && s) begin
         m_err = m_coll;
         part.delete();
         part.push_back(d);
         m_coll = 1'b1;
         m_stb  = NCH'(1);
         m_bit  = d;
      end else if (v && m_coll) begin
         part.push_back(d);
         m_stb = NCH'(1) << (part.size() - 1);
         m_bit = d;
         if (part.size() == NCH) begin
            for (int i = 0; i < NCH; i++) m_frame[i] = part[i];
            m_fv = 1'b1;
            part.delete();
            m_coll = 1'b0;
         end
      end
   endtask

   task automatic cyc(input logic r, input logic v,
                      input logic s, input logic d);
      rst_n         = r;
      bus.din_valid = v;
      bus.sof       = s;
      bus.din       = d;
      @(posedge clk);
      model(r, v, s, d);
      #1;
      chk("frame", 32'(bus.frame), 32'(m_frame));
      chk("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
      chk("ch_strobe", 32'(bus.ch_strobe), 32'(m_stb));
      chk("ch_bit", 32'(bus.ch_bit), 32'(m_bit));
      chk("slot", 32'(bus.slot), 32'(part.size()));
      chk("sync_err", 32'(bus.sync_err), 32'(m_err));
   endtask

   task automatic send_bits(input logic [NCH-1:0] val,
                            input int first, input int last,
                            input int gap, input logic lead_sof);
      for (int k = first; k <= last; k++) begin
         cyc(1'b1, 1'b1, lead_sof && (k == first), val[k]);
         for (int g = 0; g < gap; g++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      part.delete();
      m_coll  = 1'b0;
      m_frame = '0;
      m_fv    = 1'b0;
      m_stb   = '0;
      m_bit   = 1'b0;
      m_err   = 1'b0;
      rst_n         = 1'b0;
      bus.din       = 1'b1;
      bus.din_valid = 1'b1;
      bus.sof       = 1'b1;

      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1);
      chk("rst_frame", 32'(bus.frame), 32'h0);

      send_bits(10'h2AA, 0, 9, 0, 1'b1);
      chk("f1_val", 32'(bus.frame), 32'h2AA);
      chk("f1_fv", 32'(bus.frame_valid), 32'h1);
      chk("f1_stb9", 32'(bus.ch_strobe), 32'h200);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("f1_fv_pulse", 32'(bus.frame_valid), 32'h0);

      send_bits(10'h01F, 0, 9, 2, 1'b1);
      chk("gap_val", 32'(bus.frame), 32'h01F);

      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
      chk("nosof_slot", 32'(bus.slot), 32'h0);
      send_bits(10'h3FF, 0, 9, 0, 1'b1);
      chk("ones_val", 32'(bus.frame), 32'h3FF);

      send_bits(10'h000, 0, 5, 0, 1'b1);
      cyc(1'b1, 1'b1, 1'b1, 1'b1);
      chk("early_err", 32'(bus.sync_err), 32'h1);
      chk("early_slot", 32'(bus.slot), 32'h1);
      chk("early_frame", 32'(bus.frame), 32'h3FF);
      send_bits(10'h000, 1, 9, 0, 1'b0);
      chk("early_bit0", 32'(bus.frame), 32'h001);

      send_bits(10'h155, 0, 9, 0, 1'b1);
      chk("b2b_a", 32'(bus.frame), 32'h155);
      send_bits(10'h2AA, 0, 9, 0, 1'b1);
      chk("b2b_b", 32'(bus.frame), 32'h2AA);
      send_bits(10'h3FF, 0, 4, 0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("mid_rst_frame", 32'(bus.frame), 32'h0);
      chk("mid_rst_slot", 32'(bus.slot), 32'h0);
      send_bits(10'h3FF, 5, 9, 0, 1'b0);
      chk("mid_rst_nofv", 32'(bus.frame_valid), 32'h0);

      for (int i = 0; i < 600; i++) begin
         cyc(logic'($urandom_range(0, 79) != 0),
             logic'($urandom_range(0, 3) != 0),
             logic'($urandom_range(0, 13) == 0),
             logic'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
